// File: rtl/psram_bridge_pkg.sv
// Shared types and constants for the PSRAM command bridge.
package psram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_e;

    localparam logic [1:0]  RW_READ  = 2'd2;
    localparam logic [1:0]  RW_WRITE = 2'd1;
    localparam logic [15:0] ERR_WORD = 16'hDEAD;
    localparam logic [15:0] ACK_WORD = 16'h4F4B;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 40;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/psram_cmd_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module psram_cmd_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/psram_cmd_bridge.sv
// UART-to-PSRAM command bridge: queues commands, runs the start/done handshake, paces replies.
// Define PSRAM_WRITE_ACK_EN to send an "OK" word back for each completed write.
module psram_cmd_bridge
    import psram_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TX_GAP_CYCLES  = 14600
) (
    input  logic        clk_PSRAM,
    input  logic        rst,
    input  logic        quad_start,
    input  logic [1:0]  read_write,
    input  logic [22:0] address,
    input  logic [15:0] data_in,
    output logic        psram_start,
    output logic        psram_read,
    output logic [22:0] psram_addr,
    output logic [15:0] psram_wdata,
    input  logic        psram_busy,
    input  logic        psram_done,
    input  logic [15:0] psram_rdata,
    output logic        send_uart,
    output logic [15:0] send_msg,
    output logic        fifo_overflow,
    output logic        bad_cmd,
    output logic        timeout_err
);

    localparam int unsigned    TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned    GAP_W    = $clog2(TX_GAP_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TX_GAP_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    cmd_t             r_cmd;
    logic [TO_W-1:0]  r_to_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [15:0]      r_resp;
    logic [15:0]      r_msg;
    logic             r_fifo_overflow;
    logic             r_bad_cmd;
    logic             r_timeout_err;

    logic             w_rw_valid;
    logic             w_push_req;
    cmd_t             w_fifo_wdata;
    logic [CMD_W-1:0] w_fifo_rdata;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_issue;
    logic             w_done;
    logic             w_timeout;
    logic             w_send;

    assign w_rw_valid   = (read_write == RW_READ) || (read_write == RW_WRITE);
    assign w_push_req   = quad_start && w_rw_valid;
    assign w_fifo_wdata = '{rd: (read_write == RW_READ), addr: address, wdata: data_in};

    psram_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_PSRAM),
        .i_rst   (rst),
        .i_push  (w_push_req),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!psram_busy) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (psram_done) begin
`ifdef PSRAM_WRITE_ACK_EN
                    w_state_next = RESPOND;
`else
                    w_state_next = r_cmd.rd ? RESPOND : IDLE;
`endif
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = RESPOND;
                end
            end
            RESPOND: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_issue   = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        w_send    = 1'b0;
        unique case (r_state)
            IDLE:    w_pop  = !w_fifo_empty;
            ISSUE:   w_issue = !psram_busy;
            WAIT: begin
                w_done    = psram_done;
                w_timeout = !psram_done && (r_to_cnt == TO_LAST);
            end
            RESPOND: w_send = (r_gap_cnt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk_PSRAM) begin
        if (rst) begin
            r_cmd           <= '0;
            r_to_cnt        <= '0;
            r_gap_cnt       <= '0;
            r_resp          <= '0;
            r_msg           <= '0;
            r_fifo_overflow <= 1'b0;
            r_bad_cmd       <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cmd <= cmd_t'(w_fifo_rdata);
            end
            if (w_issue) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_done && r_cmd.rd) begin
                r_resp <= psram_rdata;
`ifdef PSRAM_WRITE_ACK_EN
            end else if (w_done) begin
                r_resp <= ACK_WORD;
`endif
            end else if (w_timeout) begin
                r_resp <= ERR_WORD;
            end
            // Gap counter runs regardless of state so replies stay spaced across commands.
            if (w_send) begin
                r_gap_cnt <= GAP_LAST;
                r_msg     <= r_resp;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            if (w_push_req && w_fifo_full && !w_pop) begin
                r_fifo_overflow <= 1'b1;
            end
            if (quad_start && !w_rw_valid) begin
                r_bad_cmd <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign psram_start   = w_issue;
    assign psram_read    = r_cmd.rd;
    assign psram_addr    = r_cmd.addr;
    assign psram_wdata   = r_cmd.wdata;
    assign send_uart     = w_send;
    assign send_msg      = w_send ? r_resp : r_msg;
    assign fifo_overflow = r_fifo_overflow;
    assign bad_cmd       = r_bad_cmd;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_psram_cmd_bridge.sv
// Scoreboard bench for psram_cmd_bridge with a behavioural PSRAM controller.
`timescale 1ns/1ps
module tb_psram_cmd_bridge;
    import psram_bridge_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 64;
    localparam int unsigned GAP   = 200;
`ifdef PSRAM_WRITE_ACK_EN
    localparam int unsigned AckSends = 1;
`else
    localparam int unsigned AckSends = 0;
`endif

    logic        clk_PSRAM = 1'b0;
    logic        rst;
    logic        quad_start;
    logic [1:0]  read_write;
    logic [22:0] address;
    logic [15:0] data_in;
    logic        psram_start;
    logic        psram_read;
    logic [22:0] psram_addr;
    logic [15:0] psram_wdata;
    logic        psram_busy;
    logic        psram_done;
    logic [15:0] psram_rdata;
    logic        send_uart;
    logic [15:0] send_msg;
    logic        fifo_overflow;
    logic        bad_cmd;
    logic        timeout_err;

    psram_cmd_bridge #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .TX_GAP_CYCLES  (GAP)
    ) dut (
        .clk_PSRAM     (clk_PSRAM),
        .rst           (rst),
        .quad_start    (quad_start),
        .read_write    (read_write),
        .address       (address),
        .data_in       (data_in),
        .psram_start   (psram_start),
        .psram_read    (psram_read),
        .psram_addr    (psram_addr),
        .psram_wdata   (psram_wdata),
        .psram_busy    (psram_busy),
        .psram_done    (psram_done),
        .psram_rdata   (psram_rdata),
        .send_uart     (send_uart),
        .send_msg      (send_msg),
        .fifo_overflow (fifo_overflow),
        .bad_cmd       (bad_cmd),
        .timeout_err   (timeout_err)
    );

    always #5 clk_PSRAM = ~clk_PSRAM;

    int cyc = 0;
    always @(posedge clk_PSRAM) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues and reference memory.
    cmd_t        iss_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] ref_mem [logic [22:0]];
    int          tq_start[$];
    int          tq_send[$];
    int          tq_done[$];

    function automatic logic [15:0] ref_read(input logic [22:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[15:0] ^ 16'hA5A5;
    endfunction

    // Behavioural PSRAM controller.
    logic [15:0] ctl_mem [logic [22:0]];
    int          ctl_lat = 3;
    int          ctl_mute_n = 0;
    int          pend_cnt = 0;
    logic        pend_rd;
    logic [22:0] pend_addr;
    logic [15:0] pend_wdata;

    initial begin
        psram_done  = 1'b0;
        psram_rdata = '0;
        forever begin
            @(posedge clk_PSRAM);
            #2;
            psram_done = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    psram_done = 1'b1;
                    tq_done.push_back(cyc);
                    if (pend_rd) begin
                        psram_rdata = ctl_mem.exists(pend_addr) ? ctl_mem[pend_addr]
                                                                : (pend_addr[15:0] ^ 16'hA5A5);
                    end else begin
                        ctl_mem[pend_addr] = pend_wdata;
                    end
                end
            end
            if (psram_start && !rst) begin
                if (ctl_mute_n > 0) begin
                    ctl_mute_n--;
                end else begin
                    pend_cnt   = ctl_lat;
                    pend_rd    = psram_read;
                    pend_addr  = psram_addr;
                    pend_wdata = psram_wdata;
                end
            end
        end
    end

    // Output monitor.
    int          n_start = 0;
    int          n_send = 0;
    int          last_send = 0;
    bit          have_send = 1'b0;
    logic [15:0] last_msg = '0;
    cmd_t        mon_e;
    logic [15:0] mon_m;

    always @(negedge clk_PSRAM) begin
        if (!rst) begin
            if (psram_start) begin
                n_start++;
                tq_start.push_back(cyc);
                if (iss_q.size() == 0) begin
                    check_eq("start_unexpected", 64'(iss_q.size()), 64'd1);
                end else begin
                    mon_e = iss_q.pop_front();
                    check_eq("issue_read", 64'(psram_read), 64'(mon_e.rd));
                    check_eq("issue_addr", 64'(psram_addr), 64'(mon_e.addr));
                    check_eq("issue_wdata", 64'(psram_wdata), 64'(mon_e.wdata));
                end
            end
            if (send_uart) begin
                if (have_send) check_eq("tx_spacing_ok", 64'((cyc - last_send) >= int'(GAP)), 64'd1);
                have_send = 1'b1;
                last_send = cyc;
                n_send++;
                tq_send.push_back(cyc);
                last_msg = send_msg;
                if (exp_q.size() == 0) begin
                    check_eq("tx_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_m = exp_q.pop_front();
                    check_eq("tx_msg", 64'(send_msg), 64'(mon_m));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_PSRAM);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] rw, input logic [22:0] a, input logic [15:0] d,
                            input bit expect_push, output int t_q);
        @(posedge clk_PSRAM);
        #1;
        quad_start = 1'b1;
        read_write = rw;
        address    = a;
        data_in    = d;
        t_q        = cyc;
        if (expect_push) begin
            iss_q.push_back('{rd: (rw == RW_READ), addr: a, wdata: d});
            if (rw == RW_READ) begin
                exp_q.push_back(ref_read(a));
            end else begin
                ref_mem[a] = d;
`ifdef PSRAM_WRITE_ACK_EN
                exp_q.push_back(ACK_WORD);
`endif
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk_PSRAM);
        #1;
        quad_start = 1'b0;
        read_write = 2'd0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        do begin
            @(posedge clk_PSRAM);
            #1;
            n++;
        end while ((iss_q.size() != 0 || exp_q.size() != 0) && n < bound);
        check_eq(tag, 64'(iss_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_PSRAM);
        #1;
        rst        = 1'b1;
        quad_start = 1'b0;
        pend_cnt   = 0;
        ctl_mute_n = 0;
        iss_q.delete();
        exp_q.delete();
        @(posedge clk_PSRAM);
        #1;
        rst       = 1'b0;
        have_send = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, 64'(psram_start), 64'd0);
        check_eq({tag, "_read"}, 64'(psram_read), 64'd0);
        check_eq({tag, "_addr"}, 64'(psram_addr), 64'd0);
        check_eq({tag, "_wdata"}, 64'(psram_wdata), 64'd0);
        check_eq({tag, "_send"}, 64'(send_uart), 64'd0);
        check_eq({tag, "_msg"}, 64'(send_msg), 64'd0);
        check_eq({tag, "_flags"}, 64'({fifo_overflow, bad_cmd, timeout_err}), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin : stim
        int t_q;
        int s0;
        int n0;
        rst        = 1'b1;
        quad_start = 1'b0;
        read_write = 2'd0;
        address    = '0;
        data_in    = '0;
        psram_busy = 1'b0;

        do_reset();
        @(negedge clk_PSRAM);
        check_all_zero("reset");

        // First read from idle: issue and reply latency.
        tq_start.delete(); tq_send.delete(); tq_done.delete();
        ctl_lat = 3;
        send_cmd(RW_READ, 23'h000050, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_drain("drain_first_read", 100);
        check_eq("issue_latency", 64'(tq_start[0] - t_q), 64'd2);
        check_eq("reply_latency", 64'(tq_send[0] - tq_done[0]), 64'd1);

        // Write then read back.
        send_cmd(RW_WRITE, 23'h000123, 16'hBEEF, 1'b1, t_q);
        send_cmd(RW_READ, 23'h000123, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_drain("drain_wr_rd", 3 * int'(GAP) + 100);
        check_eq("read_beef", 64'(last_msg), 64'h0000_BEEF);

        // Write to top address: ack only when enabled.
        wait_cycles(GAP + 5);
        n0 = n_send;
        send_cmd(RW_WRITE, 23'h7FFFFF, 16'h1234, 1'b1, t_q);
        idle_in();
        wait_drain("drain_write_ack", int'(GAP) + 100);
        wait_cycles(GAP + 20);
        check_eq("write_ack_sends", 64'(n_send - n0), 64'(AckSends));

        // Overflow with controller busy.
        s0 = n_start;
        @(posedge clk_PSRAM);
        #1;
        psram_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_cmd(RW_READ, 23'h000100 + 23'(i), 16'h0000, 1'b1, t_q);
        end
        @(negedge clk_PSRAM);
        check_eq("no_overflow_at_5", 64'(fifo_overflow), 64'd0);
        send_cmd(RW_READ, 23'h000200, 16'h0000, 1'b0, t_q);
        idle_in();
        @(negedge clk_PSRAM);
        check_eq("overflow_set", 64'(fifo_overflow), 64'd1);
        wait_cycles(5);
        check_eq("busy_holds_start", 64'(n_start - s0), 64'd0);
        psram_busy = 1'b0;
        wait_drain("drain_overflow", 6 * (int'(GAP) + 20) + 100);
        check_eq("overflow_starts", 64'(n_start - s0), 64'd5);

        // Timeout on the first command, the queued one still completes.
        wait_cycles(GAP + 5);
        check_eq("timeout_err_clear", 64'(timeout_err), 64'd0);
        tq_start.delete(); tq_send.delete(); tq_done.delete();
        ctl_mute_n = 1;
        send_cmd(RW_READ, 23'h000300, 16'h0000, 1'b0, t_q);
        iss_q.push_back('{rd: 1'b1, addr: 23'h000300, wdata: 16'h0000});
        exp_q.push_back(ERR_WORD);
        send_cmd(RW_READ, 23'h000301, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_drain("drain_timeout", int'(TO) + int'(GAP) + 100);
        check_eq("timeout_latency", 64'(tq_send[0] - tq_start[0]), 64'(TO + 1));
        check_eq("timeout_err_set", 64'(timeout_err), 64'd1);
        check_eq("timeout_next_issued", 64'(tq_start.size()), 64'd2);

        // Two reads completing 10 cycles apart.
        wait_cycles(GAP + 5);
        tq_start.delete(); tq_send.delete(); tq_done.delete();
        ctl_lat = 1;
        send_cmd(RW_READ, 23'h000400, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_cycles(8);
        send_cmd(RW_READ, 23'h000401, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_drain("drain_gap", int'(GAP) + 100);
        check_eq("gap_done_spacing", 64'(tq_done[1] - tq_done[0]), 64'd10);
        check_eq("gap_exact", 64'(tq_send[1] - tq_send[0]), 64'(GAP));

        // Invalid read_write codes.
        check_eq("bad_cmd_clear", 64'(bad_cmd), 64'd0);
        s0 = n_start;
        send_cmd(2'd0, 23'h000500, 16'h0000, 1'b0, t_q);
        send_cmd(2'd3, 23'h000501, 16'h0000, 1'b0, t_q);
        idle_in();
        wait_cycles(10);
        check_eq("bad_cmd_set", 64'(bad_cmd), 64'd1);
        check_eq("bad_cmd_no_push", 64'(n_start - s0), 64'd0);

        // Reset while waiting on the controller.
        ctl_mute_n = 1;
        send_cmd(RW_READ, 23'h000600, 16'h0000, 1'b1, t_q);
        idle_in();
        wait_cycles(5);
        s0 = n_start;
        n0 = n_send;
        do_reset();
        @(negedge clk_PSRAM);
        check_all_zero("mid_reset");
        wait_cycles(TO + GAP + 20);
        check_eq("post_reset_no_send", 64'(n_send - n0), 64'd0);
        check_eq("post_reset_no_start", 64'(n_start - s0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
